muldiv_sequencer: RTL and testbench

Control sequencer that drives the datapath through the full MUL/DIV instruction flow: fetch (T0–T2), operand staging (T3–T4), a handshaked wait on the multi-cycle multiplier/divider (T5), and LO/HI writeback (T6–T7). It replaces hand-timed control strobes with a Moore FSM. It waits on memory-read and ALU-completion handshakes instead of fixed delays, and it aborts on ALU timeout. It sits between the instruction issue logic and the datapath control inputs.

---
 rtl/muldiv_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Moore control sequencer for one MUL/DIV instruction. It fetches the
// instruction (T0-T2, stretched by T1W while memory is not ready), stages the
// two source operands (T3-T4), waits in T5 for the multi-cycle multiplier /
// divider to finish (with a timeout into ERR), and writes LO then HI (T6-T7).
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   synchronous, active-high; returns to IDLE, clears op/wait
//   start      in   request one instruction; only looked at in IDLE
//   op_div     in   1 = DIV, 0 = MUL; captured with the accepted start
//   mem_ready  in   memory read data valid (looked at in T1/T1W only)
//   alu_done   in   ALU result valid (looked at in T5 only)
//   PCout .. LOin   out  datapath control strobes of the same names
//   Rx_out     out  drive first source register (IR Rb) onto the bus
//   Ry_out     out  drive second source register (IR Rc) onto the bus
//   MUL, DIV   out  ALU operation select, never both high
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse in T7
//   error      out  one-cycle pulse in ERR (ALU timeout)
//
// All outputs are decoded from registered state only; no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int MAX_WAIT = 64  // T5 cycles allowed before abort, 2..255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op_div,
    input  logic mem_ready,
    input  logic alu_done,
    output logic PCout,
    output logic MARin,
    output logic IncPC,
    output logic Zin,
    output logic Zlowout,
    output logic Zhighout,
    output logic PCin,
    output logic Read,
    output logic MDRin,
    output logic MDRout,
    output logic IRin,
    output logic Yin,
    output logic HIin,
    output logic LOin,
    output logic Rx_out,
    output logic Ry_out,
    output logic MUL,
    output logic DIV,
    output logic busy,
    output logic done,
    output logic error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_ERR
    } state_t;

    // Last T5 cycle index before the timeout fires (wait_cnt counts from 0).
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    logic       op_q, op_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= 1'b0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = wait_cnt_q;

        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rx_out   = 1'b0;
        Ry_out   = 1'b0;
        MUL      = 1'b0;
        DIV      = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        error    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    op_d       = op_div;
                    wait_cnt_d = 8'd0;
                    state_d    = S_T0;
                end
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = mem_ready ? S_T2 : S_T1W;
            end
            S_T1W: begin
                // PC was already updated in T1; only keep the read open.
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) begin
                    state_d = S_T2;
                end
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                Rx_out  = 1'b1;
                Yin     = 1'b1;
                state_d = S_T4;
            end
            S_T4: begin
                Ry_out     = 1'b1;
                Zin        = 1'b1;
                MUL        = ~op_q;
                DIV        = op_q;
                wait_cnt_d = 8'd0;
                state_d    = S_T5;
            end
            S_T5: begin
                // Operands and op select held stable for the whole ALU run.
                Ry_out = 1'b1;
                Zin    = 1'b1;
                MUL    = ~op_q;
                DIV    = op_q;
                // A result arriving on the timeout cycle still counts.
                if (alu_done) begin
                    state_d = S_T6;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_T6: begin
                Zlowout = 1'b1;
                LOin    = 1'b1;
                state_d = S_T7;
            end
            S_T7: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            S_ERR: begin
                error   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int MW = 12;

    logic clk = 1'b0;
    logic reset, start, op_div, mem_ready, alu_done;
    logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin;
    logic MDRout, IRin, Yin, HIin, LOin, Rx_out, Ry_out, MUL, DIV;
    logic busy, done, error;

    always #5 clk = ~clk;

    muldiv_sequencer #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .start(start), .op_div(op_div),
        .mem_ready(mem_ready), .alu_done(alu_done),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Rx_out(Rx_out), .Ry_out(Ry_out),
        .MUL(MUL), .DIV(DIV), .busy(busy), .done(done), .error(error)
    );

    logic [20:0] strb;
    assign strb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
                   MDRin, MDRout, IRin, Yin, HIin, LOin, Rx_out, Ry_out,
                   MUL, DIV, busy, done, error};

    localparam logic [20:0] M_PCOUT  = 21'(1) << 20;
    localparam logic [20:0] M_MARIN  = 21'(1) << 19;
    localparam logic [20:0] M_INCPC  = 21'(1) << 18;
    localparam logic [20:0] M_ZIN    = 21'(1) << 17;
    localparam logic [20:0] M_ZLOW   = 21'(1) << 16;
    localparam logic [20:0] M_ZHIGH  = 21'(1) << 15;
    localparam logic [20:0] M_PCIN   = 21'(1) << 14;
    localparam logic [20:0] M_READ   = 21'(1) << 13;
    localparam logic [20:0] M_MDRIN  = 21'(1) << 12;
    localparam logic [20:0] M_MDROUT = 21'(1) << 11;
    localparam logic [20:0] M_IRIN   = 21'(1) << 10;
    localparam logic [20:0] M_YIN    = 21'(1) << 9;
    localparam logic [20:0] M_HIIN   = 21'(1) << 8;
    localparam logic [20:0] M_LOIN   = 21'(1) << 7;
    localparam logic [20:0] M_RX     = 21'(1) << 6;
    localparam logic [20:0] M_RY     = 21'(1) << 5;
    localparam logic [20:0] M_MUL    = 21'(1) << 4;
    localparam logic [20:0] M_DIV    = 21'(1) << 3;
    localparam logic [20:0] M_BUSY   = 21'(1) << 2;
    localparam logic [20:0] M_DONE   = 21'(1) << 1;
    localparam logic [20:0] M_ERROR  = 21'(1) << 0;

    localparam int ST_IDLE = 0, ST_T0 = 1, ST_T1 = 2, ST_T1W = 3, ST_T2 = 4;
    localparam int ST_T3 = 5, ST_T4 = 6, ST_T5 = 7, ST_T6 = 8, ST_T7 = 9;
    localparam int ST_ERR = 10;

    function automatic logic [20:0] exp_strb(input int st, input bit div);
        logic [20:0] s;
        s = '0;
        case (st)
            ST_T0:  s = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY;
            ST_T1:  s = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_BUSY;
            ST_T1W: s = M_READ | M_MDRIN | M_BUSY;
            ST_T2:  s = M_MDROUT | M_IRIN | M_BUSY;
            ST_T3:  s = M_RX | M_YIN | M_BUSY;
            ST_T4, ST_T5: s = M_RY | M_ZIN | (div ? M_DIV : M_MUL) | M_BUSY;
            ST_T6:  s = M_ZLOW | M_LOIN | M_BUSY;
            ST_T7:  s = M_ZHIGH | M_HIIN | M_DONE | M_BUSY;
            ST_ERR: s = M_ERROR | M_BUSY;
            default: s = '0;
        endcase
        return s;
    endfunction

    // Small datapath model driven by the strobes.
    logic [31:0] R2 = '0, R4 = '0, mdatain = '0;
    logic [31:0] MDR = '0, IR = '0, Y = '0, LO = '0, HI = '0;
    logic [63:0] Z = '0;
    logic [31:0] bus;

    always_comb bus = Rx_out ? R2 : (Ry_out ? R4 : (MDRout ? MDR : 32'h0));

    always @(posedge clk) begin
        if (MDRin && Read && mem_ready) MDR <= mdatain;
        if (IRin) IR <= bus;
        if (Yin)  Y  <= bus;
        if (Zin && alu_done && MUL) Z <= 64'(Y) * 64'(bus);
        if (Zin && alu_done && DIV && bus != 32'h0) Z <= {Y % bus, Y / bus};
        if (LOin) LO <= Z[31:0];
        if (HIin) HI <= Z[63:32];
    end

    int n_done = 0, n_err = 0, n_hilo = 0, n_pcin = 0;
    always @(negedge clk) begin
        if (done)         n_done++;
        if (error)        n_err++;
        if (HIin || LOin) n_hilo++;
        if (PCin)         n_pcin++;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from IDLE and checks the strobes every cycle.
    // stall    : number of T1W cycles
    // alu_wait : T5 cycle index (0-based) in which alu_done is raised;
    //            >= MW means never
    // poke     : pulse start during T3
    task automatic exec(input bit div, input int stall, input int alu_wait, input bit poke);
        start     = 1'b1;
        op_div    = div;
        mem_ready = (stall == 0);
        alu_done  = 1'b0;
        tick;
        start  = 1'b0;
        op_div = ~div;
        check("T0", strb, exp_strb(ST_T0, div));
        tick;
        check("T1", strb, exp_strb(ST_T1, div));
        for (int k = 1; k <= stall; k++) begin
            tick;
            mem_ready = (k == stall);
            check("T1W", strb, exp_strb(ST_T1W, div));
        end
        tick;
        mem_ready = 1'b0;
        check("T2", strb, exp_strb(ST_T2, div));
        tick;
        start = poke;
        check("T3", strb, exp_strb(ST_T3, div));
        tick;
        start = 1'b0;
        check("T4", strb, exp_strb(ST_T4, div));
        for (int j = 0; j < MW; j++) begin
            tick;
            alu_done = (j == alu_wait);
            check("T5", strb, exp_strb(ST_T5, div));
            if (j == alu_wait) break;
        end
        tick;
        alu_done = 1'b0;
        if (alu_wait < MW) begin
            check("T6", strb, exp_strb(ST_T6, div));
            tick;
            check("T7", strb, exp_strb(ST_T7, div));
        end else begin
            check("ERR", strb, exp_strb(ST_ERR, div));
        end
        tick;
        check("IDLE", strb, exp_strb(ST_IDLE, div));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int d0, e0, h0, p0;

        // Reset overrides a simultaneous start.
        reset = 1'b1; start = 1'b1; op_div = 1'b0; mem_ready = 1'b0; alu_done = 1'b0;
        tick;
        tick;
        check("rst_outs", strb, 21'h0);
        reset = 1'b0; start = 1'b0;
        tick;
        check("rst_idle", strb, 21'h0);

        // MUL, zero wait: 4 * 2 = 8.
        R2 = 32'd4; R4 = 32'd2; mdatain = 32'h12345678;
        d0 = n_done;
        exec(1'b0, 0, 0, 1'b0);
        check("mul_lo", LO, 64'd8);
        check("mul_hi", HI, 64'd0);
        check("mul_done_cnt", n_done - d0, 1);

        // DIV with slow ALU, issued back-to-back: 26 / 4 = 6 rem 2.
        R2 = 32'd26; R4 = 32'd4;
        d0 = n_done;
        exec(1'b1, 0, 10, 1'b0);
        check("div_lo", LO, 64'd6);
        check("div_hi", HI, 64'd2);
        check("div_done_cnt", n_done - d0, 1);

        // Memory stall of three T1W cycles.
        mdatain = 32'h4A920000;
        p0 = n_pcin;
        exec(1'b0, 3, 0, 1'b0);
        check("stall_ir", IR, 64'h4A920000);
        check("stall_pcin_cnt", n_pcin - p0, 1);

        // ALU timeout.
        d0 = n_done; e0 = n_err; h0 = n_hilo;
        exec(1'b0, 0, 1000, 1'b0);
        check("tmo_err_cnt", n_err - e0, 1);
        check("tmo_hilo_cnt", n_hilo - h0, 0);
        check("tmo_done_cnt", n_done - d0, 0);

        // alu_done on the timeout cycle wins.
        d0 = n_done; e0 = n_err;
        exec(1'b0, 0, MW - 1, 1'b0);
        check("tie_err_cnt", n_err - e0, 0);
        check("tie_done_cnt", n_done - d0, 1);

        // Reset in the middle of T5.
        start = 1'b1; op_div = 1'b1; mem_ready = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick; tick; tick;
        mem_ready = 1'b0;
        check("pre_rst_T5", strb, exp_strb(ST_T5, 1'b1));
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rst_T5_outs", strb, 21'h0);
        tick;
        check("rst_T5_idle", strb, 21'h0);

        // start during T3 is neither accepted nor queued.
        R2 = 32'd7; R4 = 32'd3;
        d0 = n_done;
        exec(1'b0, 0, 2, 1'b1);
        check("poke_done_cnt", n_done - d0, 1);
        check("poke_lo", LO, 64'd21);
        tick;
        check("poke_no_queue", strb, 21'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
